// File: rtl/wb_arbiter_2_pkg.sv
// Shared types for the two-master Wishbone arbiter: FSM encoding and watchdog sizing.
package wb_arbiter_2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arb_state_t;

    // A zero-width counter is illegal, so a disabled watchdog still gets one bit.
    function automatic int wd_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_sel.sv
// Two-input round-robin selector: picks the requester that was not served last on a tie.
module wb_arbiter_rr_sel (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_idx
);

    assign grant_valid = |req;
    assign grant_idx   = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/wb_arbiter_2.sv
// Two-master, one-slave Wishbone classic arbiter with cyc-locked round-robin grant
// and a watchdog that errors out a stalled slave.
module wb_arbiter_2
    import wb_arbiter_2_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT      = 1024
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   wbm0_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm0_dat_i,
    input  logic                    wbm0_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm0_sel_i,
    input  logic                    wbm0_stb_i,
    input  logic                    wbm0_cyc_i,
    output logic [DATA_WIDTH-1:0]   wbm0_dat_o,
    output logic                    wbm0_ack_o,
    output logic                    wbm0_err_o,
    output logic                    wbm0_rty_o,

    input  logic [ADDR_WIDTH-1:0]   wbm1_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm1_dat_i,
    input  logic                    wbm1_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm1_sel_i,
    input  logic                    wbm1_stb_i,
    input  logic                    wbm1_cyc_i,
    output logic [DATA_WIDTH-1:0]   wbm1_dat_o,
    output logic                    wbm1_ack_o,
    output logic                    wbm1_err_o,
    output logic                    wbm1_rty_o,

    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    output logic                    wbs_cyc_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    input  logic                    wbs_ack_i,
    input  logic                    wbs_err_i,
    input  logic                    wbs_rty_i
);

    localparam int              WD_W    = wd_width(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t      state, state_nxt;
    logic            last, last_nxt;
    logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
    logic            wd_fire, wd_fire_nxt;
    logic            rearb, grant_valid, grant_idx;
    logic            slave_resp;
    logic            fwd_ack, fwd_err, fwd_rty;

    assign slave_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

    wb_arbiter_rr_sel u_rr_sel (
        .req         ({wbm1_cyc_i, wbm0_cyc_i}),
        .last        (last),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            last    <= 1'b1;
            wd_cnt  <= '0;
            wd_fire <= 1'b0;
        end else begin
            state   <= state_nxt;
            last    <= last_nxt;
            wd_cnt  <= wd_cnt_nxt;
            wd_fire <= wd_fire_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            ST_GRANT0: rearb = ~wbm0_cyc_i;
            ST_GRANT1: rearb = ~wbm1_cyc_i;
            default:   rearb = 1'b1;
        endcase
        if (rearb) begin
            if (grant_valid) begin
                state_nxt = grant_idx ? ST_GRANT1 : ST_GRANT0;
                last_nxt  = grant_idx;
            end else begin
                state_nxt = ST_IDLE;
            end
        end

        // Fire only on a live strobe, so the forced-low fire cycle cannot re-arm it.
        wd_fire_nxt = (TIMEOUT != 0) && wbs_stb_o && !slave_resp && (wd_cnt == WD_LAST);
        if (wd_fire_nxt || state_nxt != state || state == ST_IDLE || slave_resp)
            wd_cnt_nxt = '0;
        else if (wbs_stb_o && TIMEOUT != 0)
            wd_cnt_nxt = wd_cnt + 1'b1;
        else
            wd_cnt_nxt = wd_cnt;
    end

    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_we_o  = 1'b0;
        wbs_sel_o = '0;
        wbs_stb_o = 1'b0;
        wbs_cyc_o = 1'b0;
        if (state == ST_GRANT0) begin
            wbs_adr_o = wbm0_adr_i;
            wbs_dat_o = wbm0_dat_i;
            wbs_we_o  = wbm0_we_i;
            wbs_sel_o = wbm0_sel_i;
            wbs_stb_o = wbm0_stb_i & ~wd_fire;
            wbs_cyc_o = wbm0_cyc_i;
        end else if (state == ST_GRANT1) begin
            wbs_adr_o = wbm1_adr_i;
            wbs_dat_o = wbm1_dat_i;
            wbs_we_o  = wbm1_we_i;
            wbs_sel_o = wbm1_sel_i;
            wbs_stb_o = wbm1_stb_i & ~wd_fire;
            wbs_cyc_o = wbm1_cyc_i;
        end

        // A dropped cyc hides late responses; a watchdog fire masks whatever the slave says.
        fwd_ack = wbs_cyc_o & wbs_ack_i & ~wd_fire;
        fwd_rty = wbs_cyc_o & wbs_rty_i & ~wd_fire;
        fwd_err = wd_fire | (wbs_cyc_o & wbs_err_i);

        wbm0_ack_o = (state == ST_GRANT0) & fwd_ack;
        wbm0_err_o = (state == ST_GRANT0) & fwd_err;
        wbm0_rty_o = (state == ST_GRANT0) & fwd_rty;
        wbm1_ack_o = (state == ST_GRANT1) & fwd_ack;
        wbm1_err_o = (state == ST_GRANT1) & fwd_err;
        wbm1_rty_o = (state == ST_GRANT1) & fwd_rty;
    end

    assign wbm0_dat_o = wbs_dat_i;
    assign wbm1_dat_o = wbs_dat_i;

endmodule
